// File: rtl/int_priority_ctrl.sv
// Four-source interrupt controller: sticky pending bits, a three-state service FSM and a one-cycle clear strobe.
// Define INTC_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed priority (source 0 highest).
module int_priority_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_src,
  input  logic [3:0] irq_en,
  input  logic       cpu_iack,
  output logic       cpu_irq,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [3:0] src_clr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] eligible;
  logic       any_eligible;
  logic [1:0] winner;
  logic       ack;
  logic [3:0] id_onehot;

  assign eligible     = pending & irq_en;
  assign any_eligible = |eligible;
  assign id_onehot    = 4'b0001 << irq_id;

`ifdef INTC_ROUND_ROBIN_EN
  // Pointer holds the last acknowledged id; the search starts one past it.
  logic [1:0] rr_ptr;
  logic [1:0] rr_idx;

  always_comb begin
    winner = 2'd0;
    rr_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      rr_idx = rr_ptr + 2'd1 + 2'(k);
      if (eligible[rr_idx]) winner = rr_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 2'b11;
    end else if (ack) begin
      rr_ptr <= irq_id;
    end
  end
`else
  always_comb begin
    winner = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (eligible[k]) winner = 2'(k);
    end
  end
`endif

  always_comb begin
    state_next = state;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (any_eligible) state_next = ASSERT;
      end
      ASSERT: begin
        if (cpu_iack) begin
          state_next = RELEASE;
          ack        = 1'b1;
        end
      end
      RELEASE: begin
        if (!cpu_iack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cpu_irq <= 1'b0;
      irq_id  <= 2'b00;
      pending <= 4'b0000;
      src_clr <= 4'b0000;
    end else begin
      state   <= state_next;
      cpu_irq <= (state_next == ASSERT);
      if (state == IDLE && any_eligible) irq_id <= winner;
      // A new request on the acknowledge edge overrides the clear.
      pending <= (pending & ~(ack ? id_onehot : 4'b0000)) | irq_src;
      src_clr <= ack ? id_onehot : 4'b0000;
    end
  end

endmodule

// File: tb/tb_int_priority_ctrl.sv
// Bench for int_priority_ctrl: directed scenarios plus random traffic, every cycle compared with a reference model.
module tb_int_priority_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_src;
  logic [3:0] irq_en;
  logic       cpu_iack;
  logic       cpu_irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] src_clr;

  int n_checks = 0;
  int n_pass   = 0;

  int_priority_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .irq_src  (irq_src),
    .irq_en   (irq_en),
    .cpu_iack (cpu_iack),
    .cpu_irq  (cpu_irq),
    .irq_id   (irq_id),
    .pending  (pending),
    .src_clr  (src_clr)
  );

  always #5 clk = ~clk;

  // Reference model: pending set as bits, service described by two flags.
  logic [3:0] m_pend;
  logic [3:0] m_clr;
  int         m_id;
  int         m_last;
  bit         m_serving;
  bit         m_releasing;

  function automatic int pick(input logic [3:0] elig, input int last);
    int start;
`ifdef INTC_ROUND_ROBIN_EN
    start = (last + 1) % 4;
`else
    start = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      if (elig[(start + k) % 4]) return (start + k) % 4;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [3:0] elig;
    logic [3:0] clr;
    if (rst) begin
      m_pend      = 4'b0;
      m_clr       = 4'b0;
      m_id        = 0;
      m_last      = 3;
      m_serving   = 1'b0;
      m_releasing = 1'b0;
    end else begin
      elig = m_pend & irq_en;
      clr  = 4'b0;
      if (m_serving) begin
        if (cpu_iack) begin
          clr         = 4'b0001 << m_id;
          m_last      = m_id;
          m_serving   = 1'b0;
          m_releasing = 1'b1;
        end
      end else if (m_releasing) begin
        if (!cpu_iack) m_releasing = 1'b0;
      end else if (elig != 4'b0) begin
        m_id      = pick(elig, m_last);
        m_serving = 1'b1;
      end
      m_pend = (m_pend & ~clr) | irq_src;
      m_clr  = clr;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(negedge clk);
    check("cpu_irq", 8'(cpu_irq), 8'(m_serving));
    if (m_serving) check("irq_id", 8'(irq_id), 8'(m_id));
    check("pending", 8'(pending), 8'(m_pend));
    check("src_clr", 8'(src_clr), 8'(m_clr));
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_cpu_irq", 8'(cpu_irq), 8'h0);
    check("rst_irq_id", 8'(irq_id), 8'h0);
    check("rst_pending", 8'(pending), 8'h0);
    check("rst_src_clr", 8'(src_clr), 8'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    int clr_pulses;
    rst      = 1'b1;
    irq_src  = 4'b0;
    irq_en   = 4'b0;
    cpu_iack = 1'b0;
    @(negedge clk);
    check("init_cpu_irq", 8'(cpu_irq), 8'h0);
    check("init_pending", 8'(pending), 8'h0);
    check("init_src_clr", 8'(src_clr), 8'h0);
    rst = 1'b0;
    tick();

    // Single request on source 2 through the full service cycle.
    irq_en = 4'hF; irq_src = 4'b0100; tick();
    check("d1_pending", 8'(pending), 8'h4);
    irq_src = 4'b0; tick();
    check("d1_cpu_irq", 8'(cpu_irq), 8'h1);
    check("d1_irq_id", 8'(irq_id), 8'h2);
    cpu_iack = 1'b1; tick();
    check("d1_src_clr", 8'(src_clr), 8'h4);
    check("d1_pend_clr", 8'(pending), 8'h0);
    cpu_iack = 1'b0; tick();
    check("d1_clr_once", 8'(src_clr), 8'h0);
    tick();

    // Two simultaneous requests, served in policy order.
    irq_src = 4'b1010; tick();
    irq_src = 4'b0; tick();
    for (int i = 0; i < 2; i++) begin
      cpu_iack = 1'b1; tick();
      cpu_iack = 1'b0; tick(); tick();
    end
    tick();
    do_reset(); tick();

    // Masked pending request is not eligible until enabled.
    irq_en = 4'b0; irq_src = 4'b0001; tick();
    irq_src = 4'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d3_masked", 8'(cpu_irq), 8'h0);
    end
    irq_en = 4'b0001; tick();
    check("d3_cpu_irq", 8'(cpu_irq), 8'h1);
    check("d3_irq_id", 8'(irq_id), 8'h0);
    do_reset(); tick();

    // Acknowledge held high: no re-assert and a single clear strobe.
    irq_en = 4'hF; irq_src = 4'b0001; tick();
    irq_src = 4'b0010; tick();
    irq_src = 4'b0; cpu_iack = 1'b1;
    clr_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (src_clr != 4'b0) clr_pulses++;
      check("d4_hold", 8'(cpu_irq), 8'h0);
    end
    cpu_iack = 1'b0; tick();
    check("d4_release", 8'(cpu_irq), 8'h0);
    tick();
    check("d4_cpu_irq", 8'(cpu_irq), 8'h1);
    check("d4_irq_id", 8'(irq_id), 8'h1);
    check("d4_pulses", 8'(clr_pulses), 8'h1);
    do_reset(); tick();

    // New request on the acknowledge edge of the same source wins over the clear.
    irq_src = 4'b0100; tick();
    irq_src = 4'b0; tick();
    cpu_iack = 1'b1; irq_src = 4'b0100; tick();
    check("d5_pend_kept", 8'(pending), 8'h4);
    cpu_iack = 1'b0; irq_src = 4'b0; tick(); tick();
    check("d5_reserve", 8'(cpu_irq), 8'h1);
    check("d5_irq_id", 8'(irq_id), 8'h2);

    // Reset mid-service with a request present across deassertion.
    irq_src = 4'b1000;
    do_reset(); tick();
    irq_src = 4'b0; tick(); tick();
    do_reset(); tick();

    // All four pending: service order follows the policy.
    irq_src = 4'hF; tick();
    irq_src = 4'b0; tick();
    for (int i = 0; i < 5; i++) begin
      cpu_iack = 1'b1; tick();
      cpu_iack = 1'b0; tick(); tick();
      if (i < 4) irq_src = 4'b0001 << i;
      tick();
      irq_src = 4'b0;
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      irq_src  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 7) == 0) irq_en = 4'($urandom);
      cpu_iack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 99) == 0) do_reset();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
